// File: rtl/climate_ctrl.sv
// Periodic multi-channel climate controller: samples sensors on a tick, drives hysteretic actuators, reports results.
// Optional macro CLIMATE_OVR_TIMEOUT_EN adds a per-channel tick countdown that expires manual overrides.
module climate_ctrl #(
    parameter int                CLK_HZ    = 1_000_000,
    parameter int                PERIOD_MS = 1000,
    parameter int                NUM_CH    = 2,
    parameter int                DW        = 8,
    parameter int                HYST      = 1,
    parameter logic [NUM_CH-1:0] CH_DIR    = 2'b01,
    parameter int                MAX_INIT  = 34,
    parameter int                MIN_INIT  = 1,
    parameter int                SENSE_TO  = 100_000,
    parameter int                OVR_TICKS = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 sens_req,
    input  logic                 sens_ack,
    input  logic [NUM_CH*DW-1:0] sens_data,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    input  logic [2:0]           cmd_ch,
    input  logic [DW-1:0]        cmd_val,
    output logic                 cmd_err,
    output logic                 tx_req,
    input  logic                 tx_done,
    output logic [NUM_CH*DW-1:0] samples,
    output logic                 disp_en,
    input  logic                 disp_done,
    output logic [NUM_CH-1:0]    act,
    output logic [2:0]           status
);

    localparam int TICK_CYC = CLK_HZ / 1000 * PERIOD_MS;
    localparam int TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int SW       = $clog2(SENSE_TO + 1);
    localparam logic [DW:0] FULL_W = {1'b0, {DW{1'b1}}};
    localparam logic [DW:0] HYST_W = (DW+1)'(HYST);

    localparam logic [1:0] OP_SET_MAX = 2'b00;
    localparam logic [1:0] OP_SET_MIN = 2'b01;
    localparam logic [1:0] OP_FORCE   = 2'b10;
    localparam logic [1:0] OP_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SENSE  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t                state_r;
    logic [TW-1:0]         tick_cnt_r;
    logic                  tick_s;
    logic [SW-1:0]         to_cnt_r;
    logic                  sens_req_r;
    logic                  tx_req_r;
    logic                  disp_en_r;
    logic [NUM_CH*DW-1:0]  samples_r;
    logic                  fault_r;
    logic                  overrun_r;
    logic                  busy_r;
    logic                  cmd_err_r;
    logic [NUM_CH-1:0]     act_r;
    logic [NUM_CH-1:0]     ovr_r;
    logic [DW-1:0]         max_r [NUM_CH];
    logic [DW-1:0]         min_r [NUM_CH];
    logic [DW-1:0]         sel_max_s;
    logic [DW-1:0]         sel_min_s;
    logic                  ch_ok_s;
    logic                  cmd_ok_s;
    logic                  cmd_acc_s;
    logic [DW:0]           thr_lo_s [NUM_CH];
    logic [DW:0]           thr_hi_s [NUM_CH];
    logic [NUM_CH-1:0]     eval_on_s;
    logic [NUM_CH-1:0]     eval_off_s;

`ifdef CLIMATE_OVR_TIMEOUT_EN
    localparam int OCW = $clog2(OVR_TICKS + 1);
    logic [OCW-1:0]        ovr_cnt_r [NUM_CH];
`endif

    assign tick_s = (tick_cnt_r == TW'(TICK_CYC - 1));

    // Free-running sample-period counter, independent of FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Sequencer: sense handshake, evaluation slot, report/display handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sens_req_r <= 1'b0;
            tx_req_r   <= 1'b0;
            disp_en_r  <= 1'b0;
            samples_r  <= '0;
            fault_r    <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
            to_cnt_r   <= '0;
        end else begin
            if (tick_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        state_r    <= ST_SENSE;
                        sens_req_r <= 1'b1;
                        busy_r     <= 1'b1;
                        to_cnt_r   <= '0;
                    end
                end
                ST_SENSE: begin
                    if (sens_ack) begin
                        samples_r  <= sens_data;
                        sens_req_r <= 1'b0;
                        state_r    <= ST_EVAL;
                    end else if (to_cnt_r == SW'(SENSE_TO - 1)) begin
                        fault_r    <= 1'b1;
                        sens_req_r <= 1'b0;
                        state_r    <= ST_EVAL;
                    end else begin
                        to_cnt_r <= to_cnt_r + SW'(1);
                    end
                end
                ST_EVAL: begin
                    state_r   <= ST_REPORT;
                    tx_req_r  <= 1'b1;
                    disp_en_r <= 1'b1;
                end
                ST_REPORT: begin
                    if (!tx_req_r && !disp_en_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        if (tx_done) begin
                            tx_req_r <= 1'b0;
                        end
                        if (disp_done) begin
                            disp_en_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sens_req_r <= 1'b0;
                    tx_req_r   <= 1'b0;
                    disp_en_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Command validation against the addressed channel's current thresholds
    always_comb begin
        sel_max_s = '0;
        sel_min_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_max_s = (cmd_ch == 3'(i)) ? max_r[i] : sel_max_s;
            sel_min_s = (cmd_ch == 3'(i)) ? min_r[i] : sel_min_s;
        end
        ch_ok_s = ({1'b0, cmd_ch} < 4'(NUM_CH));
        case (cmd_op)
            OP_SET_MAX: cmd_ok_s = ch_ok_s && (cmd_val >= sel_min_s);
            OP_SET_MIN: cmd_ok_s = ch_ok_s && (cmd_val <= sel_max_s);
            default:    cmd_ok_s = ch_ok_s;
        endcase
        cmd_acc_s = cmd_valid && cmd_ok_s;
    end

    // Hysteresis thresholds, widened one bit so they saturate instead of wrapping
    always_comb begin
        eval_on_s  = '0;
        eval_off_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            thr_lo_s[i] = ({1'b0, max_r[i]} >= HYST_W) ? ({1'b0, max_r[i]} - HYST_W) : '0;
            thr_hi_s[i] = (({1'b0, min_r[i]} + HYST_W) > FULL_W) ? FULL_W
                                                                : ({1'b0, min_r[i]} + HYST_W);
            eval_on_s[i]  = CH_DIR[i] ? (samples_r[i*DW +: DW] > max_r[i])
                                      : (samples_r[i*DW +: DW] < min_r[i]);
            eval_off_s[i] = CH_DIR[i] ? ({1'b0, samples_r[i*DW +: DW]} <= thr_lo_s[i])
                                      : ({1'b0, samples_r[i*DW +: DW]} >= thr_hi_s[i]);
        end
    end

    // Thresholds, overrides and actuators; a force/release beats EVAL on its channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_r <= 1'b0;
            act_r     <= '0;
            ovr_r     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                max_r[i] <= DW'(MAX_INIT);
                min_r[i] <= DW'(MIN_INIT);
`ifdef CLIMATE_OVR_TIMEOUT_EN
                ovr_cnt_r[i] <= '0;
`endif
            end
        end else begin
            cmd_err_r <= cmd_valid && !cmd_ok_s;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmd_acc_s && (cmd_ch == 3'(i)) && (cmd_op == OP_SET_MAX)) begin
                    max_r[i] <= cmd_val;
                end
                if (cmd_acc_s && (cmd_ch == 3'(i)) && (cmd_op == OP_SET_MIN)) begin
                    min_r[i] <= cmd_val;
                end
                if (cmd_acc_s && (cmd_ch == 3'(i)) && (cmd_op == OP_FORCE)) begin
                    ovr_r[i] <= 1'b1;
                    act_r[i] <= cmd_val[0];
                end else if (cmd_acc_s && (cmd_ch == 3'(i)) && (cmd_op == OP_RELEASE)) begin
                    ovr_r[i] <= 1'b0;
                end else begin
`ifdef CLIMATE_OVR_TIMEOUT_EN
                    if (tick_s && ovr_r[i] && (ovr_cnt_r[i] <= OCW'(1))) begin
                        ovr_r[i] <= 1'b0;
                    end
`endif
                    if ((state_r == ST_EVAL) && !ovr_r[i]) begin
                        if (eval_on_s[i]) begin
                            act_r[i] <= 1'b1;
                        end else if (eval_off_s[i]) begin
                            act_r[i] <= 1'b0;
                        end
                    end
                end
`ifdef CLIMATE_OVR_TIMEOUT_EN
                if (cmd_acc_s && (cmd_ch == 3'(i)) && (cmd_op == OP_FORCE)) begin
                    ovr_cnt_r[i] <= OCW'(OVR_TICKS);
                end else if (tick_s && ovr_r[i] && (ovr_cnt_r[i] != '0)) begin
                    ovr_cnt_r[i] <= ovr_cnt_r[i] - OCW'(1);
                end
`endif
            end
        end
    end

    assign sens_req = sens_req_r;
    assign tx_req   = tx_req_r;
    assign disp_en  = disp_en_r;
    assign samples  = samples_r;
    assign cmd_err  = cmd_err_r;
    assign act      = act_r;
    assign status   = {overrun_r, fault_r, busy_r};

endmodule

// File: tb/tb_climate_ctrl.sv
// Directed bench for climate_ctrl: vector table for hysteresis, hand sequences for commands, timeout, overrun, reset.
module tb_climate_ctrl;

    localparam int NUM_CH   = 2;
    localparam int DW       = 8;
    localparam int TICK     = 100;
    localparam int SENSE_TO = 40;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sens_req;
    logic                 sens_ack = 1'b0;
    logic [NUM_CH*DW-1:0] sens_data = '0;
    logic                 cmd_valid = 1'b0;
    logic [1:0]           cmd_op = 2'b00;
    logic [2:0]           cmd_ch = 3'd0;
    logic [DW-1:0]        cmd_val = '0;
    logic                 cmd_err;
    logic                 tx_req;
    logic                 tx_done = 1'b0;
    logic [NUM_CH*DW-1:0] samples;
    logic                 disp_en;
    logic                 disp_done = 1'b0;
    logic [NUM_CH-1:0]    act;
    logic [2:0]           status;

    climate_ctrl #(
        .CLK_HZ(100_000), .PERIOD_MS(1), .NUM_CH(NUM_CH), .DW(DW), .HYST(1),
        .CH_DIR(2'b01), .MAX_INIT(34), .MIN_INIT(1), .SENSE_TO(SENSE_TO), .OVR_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sens_req(sens_req), .sens_ack(sens_ack),
        .sens_data(sens_data), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
        .cmd_val(cmd_val), .cmd_err(cmd_err), .tx_req(tx_req), .tx_done(tx_done),
        .samples(samples), .disp_en(disp_en), .disp_done(disp_done), .act(act),
        .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [1:0] act;
    } vec_t;

    vec_t vecs [8];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return sens_req;
            1:       return tx_req;
            2:       return status[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic val, input int lim, input string name);
        int n = 0;
        while ((sig_of(which) !== val) && (n < lim)) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(sig_of(which)), int'(val));
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] ch, input logic [7:0] val,
                            input int exp_err, input string name);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_val   = val;
        @(negedge clk);
        cmd_valid = 1'b0;
        check(name, int'(cmd_err), exp_err);
    endtask

    task automatic ack_sample(input logic [7:0] s0, input logic [7:0] s1, input string name);
        wait_for(0, 1'b1, 2*TICK, {name, " sens_req"});
        sens_data = {s1, s0};
        sens_ack  = 1'b1;
        @(negedge clk);
        sens_ack = 1'b0;
        wait_for(1, 1'b1, 5, {name, " tx_req"});
        check({name, " samples"}, int'(samples), int'({s1, s0}));
    endtask

    task automatic run_sample(input logic [7:0] s0, input logic [7:0] s1, input string name);
        ack_sample(s0, s1, name);
        tx_done   = 1'b1;
        disp_done = 1'b1;
        @(negedge clk);
        tx_done   = 1'b0;
        disp_done = 1'b0;
        wait_for(2, 1'b0, 5, {name, " idle"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   n;
        logic seen_req;
        int   exp_a;

        vecs[0] = '{8'd35,  8'd41,  2'b11};
        vecs[1] = '{8'd34,  8'd42,  2'b11};
        vecs[2] = '{8'd33,  8'd43,  2'b00};
        vecs[3] = '{8'd0,   8'd255, 2'b00};
        vecs[4] = '{8'd255, 8'd0,   2'b11};
        vecs[5] = '{8'd34,  8'd42,  2'b11};
        vecs[6] = '{8'd33,  8'd41,  2'b10};
        vecs[7] = '{8'd34,  8'd43,  2'b00};

        repeat (3) @(negedge clk);
        check("reset sens_req", int'(sens_req), 0);
        check("reset tx_req", int'(tx_req), 0);
        check("reset disp_en", int'(disp_en), 0);
        check("reset cmd_err", int'(cmd_err), 0);
        check("reset act", int'(act), 0);
        check("reset status", int'(status), 0);
        check("reset samples", int'(samples), 0);
        rst_n = 1'b1;

        send_cmd(2'b00, 3'd1, 8'd100, 0, "ch1 set max 100");
        send_cmd(2'b01, 3'd1, 8'd42,  0, "ch1 set min 42");
        send_cmd(2'b01, 3'd0, 8'd50,  1, "ch0 set min 50 above max");
        @(negedge clk);
        check("cmd_err single pulse", int'(cmd_err), 0);
        send_cmd(2'b00, 3'd5, 8'd10,  1, "bad channel 5");
        send_cmd(2'b00, 3'd0, 8'd0,   1, "ch0 set max below min");
        send_cmd(2'b00, 3'd0, 8'd40,  0, "ch0 min still 1");
        send_cmd(2'b00, 3'd0, 8'd34,  0, "ch0 max back to 34");

        for (int i = 0; i < 8; i++) begin
            run_sample(vecs[i].s0, vecs[i].s1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d act", i), int'(act), int'(vecs[i].act));
        end
        check("status after table", int'(status), 0);

        send_cmd(2'b10, 3'd0, 8'd1, 0, "force ch0");
        check("force act visible", int'(act), 1);
        run_sample(8'd0, 8'd43, "forced1");
        check("forced eval1 act", int'(act), 1);
        run_sample(8'd0, 8'd43, "forced2");
`ifdef CLIMATE_OVR_TIMEOUT_EN
        exp_a = 0;
`else
        exp_a = 1;
`endif
        check("forced eval2 act", int'(act), exp_a);
        send_cmd(2'b11, 3'd0, 8'd0, 0, "release ch0");
        check("release holds act", int'(act), exp_a);
        run_sample(8'd0, 8'd43, "released");
        check("released eval act", int'(act), 0);

        wait_for(0, 1'b1, 2*TICK, "timeout sens_req");
        n = 0;
        while (sens_req && (n < SENSE_TO + 20)) begin
            n++;
            @(negedge clk);
        end
        check("timeout sens_req cycles", n, SENSE_TO);
        check("timeout fault", int'(status[1]), 1);
        check("timeout samples kept", int'(samples), int'({8'd43, 8'd0}));
        wait_for(1, 1'b1, 5, "timeout tx_req");
        check("timeout disp_en", int'(disp_en), 1);
        disp_done = 1'b1;
        @(negedge clk);
        disp_done = 1'b0;
        check("disp_en dropped alone", int'(disp_en), 0);
        check("tx_req held", int'(tx_req), 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_for(2, 1'b0, 5, "timeout idle");
        check("no overrun yet", int'(status[2]), 0);

        ack_sample(8'd20, 8'd50, "overrun");
        disp_done = 1'b1;
        @(negedge clk);
        disp_done = 1'b0;
        seen_req = 1'b0;
        for (int k = 0; k < TICK + 20; k++) begin
            @(negedge clk);
            seen_req = seen_req | sens_req;
        end
        check("overrun flag", int'(status[2]), 1);
        check("overrun tick skipped", int'(seen_req), 0);
        check("overrun tx_req held", int'(tx_req), 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_for(2, 1'b0, 5, "overrun idle");
        run_sample(8'd35, 8'd50, "after overrun");
        check("after overrun act", int'(act), 1);
        check("overrun sticky", int'(status[2]), 1);

        ack_sample(8'd35, 8'd50, "reset cycle");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst tx_req drop", int'(tx_req), 0);
        check("rst disp_en drop", int'(disp_en), 0);
        check("rst status", int'(status), 0);
        check("rst act", int'(act), 0);
        check("rst samples", int'(samples), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_done   = 1'b1;
        disp_done = 1'b1;
        @(negedge clk);
        tx_done   = 1'b0;
        disp_done = 1'b0;
        @(negedge clk);
        check("late done ignored tx_req", int'(tx_req), 0);
        check("late done ignored status", int'(status), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
